shift_frame_receiver: RTL

Serial frame receiver that sits directly downstream of the 4-bit parallel-load shift register. It samples the register's serial output (Q[3], MSB first) on bit-strobe cycles and detects a start bit. It then assembles WIDTH data bits, checks optional parity and the stop bit, and presents each good word with a one-cycle valid pulse, or flags a framing/parity error.

---
 rtl/shift_rx_pkg.sv | 21 ++
 rtl/shift_rx_bitcnt.sv | 35 +++
 rtl/shift_frame_receiver.sv | 99 +++++++++
 3 files changed

// File: rtl/shift_rx_pkg.sv
// Shared definitions for the serial frame receiver: FSM encoding and
// parity / frame-length helpers.
package shift_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } rx_state_t;

  // Even parity is the plain XOR of the data; odd parity inverts it.
  function automatic logic parity_of(input logic [31:0] word, input logic odd);
    return (^word) ^ odd;
  endfunction

  function automatic int frame_len(input int width, input int parity_en);
    return width + 2 + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage

// File: rtl/shift_rx_bitcnt.sv
// Data-bit counter for the frame receiver; flags the last data bit of a frame.
module shift_rx_bitcnt #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, optional
// parity, stop bit; registered word/valid/error/busy outputs.
module shift_frame_receiver
  import shift_rx_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1,
  parameter int ODD       = 0
) (
  input  logic             C,
  input  logic             R,
  input  logic             S,
  input  logic             EN,
  output logic [WIDTH-1:0] Q,
  output logic             V,
  output logic             E,
  output logic             B
);

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             perr_q, perr_d;
  logic             v_q, v_d;
  logic             e_q, e_d;
  logic             b_q, b_d;
  logic             cnt_last;

  shift_rx_bitcnt #(
    .WIDTH(WIDTH)
  ) u_bitcnt (
    .clk (C),
    .rst (R),
    .clr (EN && (state_q == IDLE) && S),
    .inc (EN && (state_q == DATA)),
    .last(cnt_last)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    q_d     = q_q;
    perr_d  = perr_q;
    v_d     = 1'b0;
    e_d     = 1'b0;
    if (EN) begin
      case (state_q)
        IDLE: if (S) state_d = DATA;
        DATA: begin
          sh_d = {sh_q[WIDTH-2:0], S};
          if (cnt_last) state_d = (PARITY_EN != 0) ? PAR : STOP;
        end
        PAR: begin
          perr_d  = S ^ parity_of(32'(sh_q), ODD != 0);
          state_d = STOP;
        end
        STOP: begin
          // A bad stop bit just drops back to IDLE; the next 1 is a new start.
          if (!S && !perr_q) begin
            q_d = sh_q;
            v_d = 1'b1;
          end else begin
            e_d = 1'b1;
          end
          perr_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    b_d = (state_d != IDLE);
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      sh_q    <= '0;
      q_q     <= '0;
      perr_q  <= 1'b0;
      v_q     <= 1'b0;
      e_q     <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      perr_q  <= perr_d;
      v_q     <= v_d;
      e_q     <= e_d;
      b_q     <= b_d;
    end
  end

  assign Q = q_q;
  assign V = v_q;
  assign E = e_q;
  assign B = b_q;

endmodule
